// File: rtl/fpcvt_sequencer.sv
// Multi-cycle sequencer for the 12-bit two's-complement -> (S,E,F) float converter.
// Stages: sign/magnitude, one-shift-per-cycle normalise, round, saturate; valid/ready both sides.
module fpcvt_sequencer #(
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [11:0] D,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        S,
    output logic [2:0]  E,
    output logic [3:0]  F,
    output logic        sat,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MAG   = 3'd1,
        NORM  = 3'd2,
        ROUND = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t      state;
    logic [11:0] d_lat;
    logic        sat_pend;
    logic [10:0] n;
    logic [2:0]  k;
    logic [2:0]  cnt;

    logic [11:0] neg_d;
    logic [10:0] mag;
    logic        norm_exit;
    logic [2:0]  e0;
    logic [3:0]  f0;
    logic        rb;
    logic [2:0]  e_rnd;
    logic [3:0]  f_rnd;
    logic        sat_rnd;

    // -2048 has no 11-bit magnitude; clamp to 2047 and let sat_pend force saturation.
    always_comb begin
        neg_d = -d_lat;
        if (d_lat == 12'h800)
            mag = 11'h7ff;
        else if (d_lat[11])
            mag = neg_d[10:0];
        else
            mag = d_lat[10:0];
    end

    // Fixed-latency mode counts NORM cycles separately from the shift count k.
    assign norm_exit = EARLY_EXIT ? (n[10] || (k == 3'd7)) : (cnt == 3'd7);

    // NOTE: every output of this block is assigned a default first, so no latch is inferred.
    always_comb begin
        e0      = 3'd7 - k;
        f0      = n[10:7];
        rb      = (k != 3'd7) && n[6];
        e_rnd   = e0;
        f_rnd   = f0;
        sat_rnd = 1'b0;
        if (sat_pend) begin
            e_rnd   = 3'd7;
            f_rnd   = 4'd15;
            sat_rnd = 1'b1;
        end else if (rb) begin
            if (f0 != 4'd15) begin
                f_rnd = f0 + 4'd1;
            end else if (e0 != 3'd7) begin
                f_rnd = 4'd8;
                e_rnd = e0 + 3'd1;
            end else begin
                f_rnd   = 4'd15;
                sat_rnd = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            S         <= 1'b0;
            E         <= 3'd0;
            F         <= 4'd0;
            sat       <= 1'b0;
            d_lat     <= 12'd0;
            sat_pend  <= 1'b0;
            n         <= 11'd0;
            k         <= 3'd0;
            cnt       <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                    if (in_valid && in_ready) begin
                        d_lat    <= D;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= MAG;
                    end
                end
                MAG: begin
                    n        <= mag;
                    k        <= 3'd0;
                    cnt      <= 3'd0;
                    sat_pend <= (d_lat == 12'h800);
                    state    <= NORM;
                end
                NORM: begin
                    if (norm_exit) begin
                        state <= ROUND;
                    end else begin
                        cnt <= cnt + 3'd1;
                        if (!n[10] && (k != 3'd7)) begin
                            n <= n << 1;
                            k <= k + 3'd1;
                        end
                    end
                end
                ROUND: begin
                    S         <= d_lat[11];
                    E         <= e_rnd;
                    F         <= f_rnd;
                    sat       <= sat_rnd;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpcvt_sequencer.sv
// Randomised bench: runs EARLY_EXIT=1 and EARLY_EXIT=0 instances in lockstep
// against an arithmetic (leading-one position) reference model.
module tb_fpcvt_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [11:0] d = 12'd0;
    logic        out_ready = 1'b0;

    logic       in_ready1, out_valid1, s1, sat1, busy1;
    logic [2:0] e1;
    logic [3:0] f1;
    logic       in_ready0, out_valid0, s0, sat0, busy0;
    logic [2:0] e0;
    logic [3:0] f0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fpcvt_sequencer #(.EARLY_EXIT(1'b1)) dut_early (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1), .D(d),
        .out_valid(out_valid1), .out_ready(out_ready), .S(s1), .E(e1), .F(f1),
        .sat(sat1), .busy(busy1)
    );

    fpcvt_sequencer #(.EARLY_EXIT(1'b0)) dut_fixed (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0), .D(d),
        .out_valid(out_valid0), .out_ready(out_ready), .S(s0), .E(e0), .F(f0),
        .sat(sat0), .busy(busy0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Reference: value = F * 2^E with F holding the top 4 bits of |D|, rounded half-up.
    function automatic void model(input logic [11:0] dv, output int s, output int e,
                                  output int f, output int sat, output int lat);
        int m, p, rb, k;
        s   = int'(dv[11]);
        sat = 0;
        m   = dv[11] ? 4096 - int'(dv) : int'(dv);
        if (m == 2048) begin
            e = 7; f = 15; sat = 1; lat = 3;
            return;
        end
        p = -1;
        for (int i = 0; i < 11; i++)
            if ((m >> i) & 1) p = i;
        k = (10 - p > 7) ? 7 : 10 - p;
        lat = k + 3;
        if (p <= 3) begin
            e = 0; f = m;
        end else begin
            e  = p - 3;
            f  = m >> e;
            rb = (m >> (e - 1)) & 1;
            f  = f + rb;
            if (f == 16) begin
                if (e < 7) begin f = 8; e = e + 1; end
                else begin f = 15; sat = 1; end
            end
        end
    endfunction

    task automatic convert(input logic [11:0] dv, input int hold);
        int xs, xe, xf, xsat, xlat;
        int lat1, lat0, cyc;
        model(dv, xs, xe, xf, xsat, xlat);
        @(negedge clk);
        check("in_ready_early_idle", 32'(in_ready1), 32'd1);
        check("in_ready_fixed_idle", 32'(in_ready0), 32'd1);
        d = dv;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        d = 12'($urandom);
        lat1 = -1;
        lat0 = -1;
        cyc  = 0;
        while ((lat1 < 0 || lat0 < 0) && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
            if (out_valid1 && lat1 < 0) lat1 = cyc;
            if (out_valid0 && lat0 < 0) lat0 = cyc;
        end
        check("latency_early", 32'(lat1), 32'(xlat));
        check("latency_fixed", 32'(lat0), 32'd10);
        check("s_early", 32'(s1), 32'(xs));
        check("e_early", 32'(e1), 32'(xe));
        check("f_early", 32'(f1), 32'(xf));
        check("sat_early", 32'(sat1), 32'(xsat));
        check("s_fixed", 32'(s0), 32'(xs));
        check("e_fixed", 32'(e0), 32'(xe));
        check("f_fixed", 32'(f0), 32'(xf));
        check("sat_fixed", 32'(sat0), 32'(xsat));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            in_valid = ~in_valid;
            d = 12'($urandom);
            @(posedge clk);
            #1;
            check("hold_valid", 32'(out_valid1 & out_valid0), 32'd1);
            check("hold_in_ready", 32'(in_ready1 | in_ready0), 32'd0);
            check("hold_outputs_early", {24'd0, s1, e1, f1}, 32'({xs[0], xe[2:0], xf[3:0]}));
            check("hold_outputs_fixed", {24'd0, s0, e0, f0}, 32'({xs[0], xe[2:0], xf[3:0]}));
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("release_valid", 32'(out_valid1 | out_valid0), 32'd0);
        check("release_in_ready", 32'(in_ready1 & in_ready0), 32'd1);
        check("release_busy", 32'(busy1 | busy0), 32'd0);
        check("after_release_hold", {23'd0, s1, e1, f1, sat1}, 32'({xs[0], xe[2:0], xf[3:0], xsat[0]}));
    endtask

    initial begin
        logic [11:0] directed [10];
        directed = '{12'h000, 12'd422, 12'd125, 12'hF83, 12'h800, 12'd2047,
                     12'd1, 12'd15, 12'd16, 12'hFFF};

        #2;
        check("reset_outputs", {22'd0, in_ready1, out_valid1, busy1, s1, e1, f1, sat1}, 32'd0);
        check("reset_outputs_fixed", {22'd0, in_ready0, out_valid0, busy0, s0, e0, f0, sat0}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("in_ready_before_edge", 32'(in_ready1), 32'd0);
        @(posedge clk);
        #1;
        check("in_ready_after_edge", 32'(in_ready1 & in_ready0), 32'd1);

        for (int i = 0; i < 10; i++)
            convert(directed[i], (i == 1) ? 5 : 0);

        // Abort mid-normalise, then confirm a clean conversion afterwards.
        @(negedge clk);
        d = 12'd125;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("busy_before_abort", 32'(busy1 & busy0), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_outputs", {22'd0, in_ready1, out_valid1, busy1, s1, e1, f1, sat1}, 32'd0);
        check("abort_outputs_fixed", {22'd0, in_ready0, out_valid0, busy0, s0, e0, f0, sat0}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        convert(12'd422, 0);

        for (int i = 0; i < 40; i++)
            convert(12'($urandom), int'($urandom_range(0, 3)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
